// File: rtl/gpr_sb_if.sv
// Register-file bus: read ports with pending flags, byte-enabled write port,
// and issue port for the RAW-hazard scoreboard.
interface gpr_sb_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rpend;
    logic              stall;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wbe;
    logic              iss;
    logic [AW-1:0]     iss_addr;
    logic [AW:0]       npend;

    // Single-cycle, unhandshaked: we/iss are sampled on every rising clk edge.
    modport master (
        output raddr, we, waddr, wdata, wbe, iss, iss_addr,
        input  rdata, rpend, stall, npend
    );

    modport slave (
        input  raddr, we, waddr, wdata, wbe, iss, iss_addr,
        output rdata, rpend, stall, npend
    );
endinterface

// File: rtl/gpr_sb.sv
// General-purpose register file with byte-enable writes, write-to-read bypass
// and a per-register pending scoreboard for decode-stage RAW stalls.
module gpr_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic     clk,
    input logic     rst,
    gpr_sb_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [AW:0]      npend_q;
    logic [AW:0]      cnt_nxt;
    logic             wr_zero;

    logic [NRD*DW-1:0] rdata_w;
    logic [NRD-1:0]    rpend_w;
    logic [AW-1:0]     ra;
    logic              hit;
    logic              zro;
    logic [DW-1:0]     word;

    assign wr_zero = (ZERO_REG != 0) && (bus.waddr == '0);

    // Issue is applied after the write-clear so a same-address issue wins.
    always_comb begin
        pend_nxt = pend;
        if (bus.we) pend_nxt[bus.waddr] = 1'b0;
        if (bus.iss && !((ZERO_REG != 0) && (bus.iss_addr == '0)))
            pend_nxt[bus.iss_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend    <= '0;
            npend_q <= '0;
        end else begin
            if (bus.we && !wr_zero) begin
                for (int b = 0; b < NB; b++)
                    if (bus.wbe[b]) regs[bus.waddr][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
            pend    <= pend_nxt;
            npend_q <= cnt_nxt;
        end
    end

    // Read ports: zero register, then bypass merge, then stored value.
    always_comb begin
        rdata_w = '0;
        rpend_w = '0;
        ra      = '0;
        hit     = 1'b0;
        zro     = 1'b0;
        word    = '0;
        for (int k = 0; k < NRD; k++) begin
            ra   = bus.raddr[k*AW +: AW];
            hit  = (BYPASS != 0) && bus.we && (ra == bus.waddr);
            zro  = ((ZERO_REG != 0) && (ra == '0)) || rst;
            word = regs[ra];
            if (hit) begin
                for (int b = 0; b < NB; b++)
                    if (bus.wbe[b]) word[b*8 +: 8] = bus.wdata[b*8 +: 8];
            end
            if (zro) word = '0;
            rdata_w[k*DW +: DW] = word;
            rpend_w[k]          = pend[ra] && !hit && !zro;
        end
    end

    assign bus.rdata = rdata_w;
    assign bus.rpend = rpend_w;
    assign bus.stall = |rpend_w;
    assign bus.npend = npend_q;
endmodule

// File: tb/tb_gpr_sb.sv
// Directed bench for gpr_sb: one bypassing instance and one non-bypassing
// instance share the same stimulus.
module tb_gpr_sb;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gpr_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus0 ();
    gpr_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus1 ();

    gpr_sb #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gpr_sb #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) u_nob (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.raddr    = bus0.raddr;
    assign bus1.we       = bus0.we;
    assign bus1.waddr    = bus0.waddr;
    assign bus1.wdata    = bus0.wdata;
    assign bus1.wbe      = bus0.wbe;
    assign bus1.iss      = bus0.iss;
    assign bus1.iss_addr = bus0.iss_addr;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        bus0.raddr = {p1, p0};
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        bus0.we    = 1'b1;
        bus0.waddr = a;
        bus0.wdata = d;
        bus0.wbe   = be;
        tick();
        bus0.we    = 1'b0;
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        bus0.iss      = 1'b1;
        bus0.iss_addr = a;
        tick();
        bus0.iss      = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus0.raddr    = '0;
        bus0.we       = 1'b0;
        bus0.waddr    = '0;
        bus0.wdata    = '0;
        bus0.wbe      = '0;
        bus0.iss      = 1'b0;
        bus0.iss_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state on every address
        check("rst_npend", 64'(bus0.npend), 64'd0);
        check("rst_stall", 64'(bus0.stall), 64'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            check("rst_rdata", 64'(bus0.rdata), 64'd0);
            check("rst_rpend", 64'(bus0.rpend), 64'd0);
        end

        // byte-enable writes and zero register
        do_write(5'd5, 32'hDEADBEEF, 4'hF);
        do_write(5'd5, 32'h000000AA, 4'h1);
        set_rd(5'd5, 5'd5);
        check("be_merge_p0", 64'(bus0.rdata[31:0]), 64'hDEADBEAA);
        check("be_merge_p1", 64'(bus0.rdata[63:32]), 64'hDEADBEAA);
        check("be_merge_nob", 64'(bus1.rdata[31:0]), 64'hDEADBEAA);
        do_write(5'd0, 32'h12345678, 4'hF);
        set_rd(5'd0, 5'd5);
        check("zero_reg", 64'(bus0.rdata), {32'hDEADBEAA, 32'h0});

        // bypass vs no bypass
        do_write(5'd7, 32'hAABBCCDD, 4'hF);
        set_rd(5'd7, 5'd5);
        bus0.we    = 1'b1;
        bus0.waddr = 5'd7;
        bus0.wdata = 32'h11223344;
        bus0.wbe   = 4'h3;
        #1;
        check("bypass_on", 64'(bus0.rdata[31:0]), 64'hAABB3344);
        check("bypass_off", 64'(bus1.rdata[31:0]), 64'hAABBCCDD);
        check("bypass_other_port", 64'(bus0.rdata[63:32]), 64'hDEADBEAA);
        tick();
        bus0.we = 1'b0;
        #1;
        check("post_bypass_wr", 64'(bus1.rdata[31:0]), 64'hAABB3344);

        // scoreboard: issue then retire reg 9
        do_issue(5'd9);
        set_rd(5'd7, 5'd9);
        check("iss9_npend", 64'(bus0.npend), 64'd1);
        check("iss9_rpend", 64'(bus0.rpend), 64'b10);
        check("iss9_stall", 64'(bus0.stall), 64'd1);
        bus0.we    = 1'b1;
        bus0.waddr = 5'd9;
        bus0.wdata = 32'h0000_0009;
        bus0.wbe   = 4'hF;
        #1;
        check("wr9_rpend_byp", 64'(bus0.rpend), 64'b00);
        check("wr9_stall_byp", 64'(bus0.stall), 64'd0);
        check("wr9_rpend_nob", 64'(bus1.rpend), 64'b10);
        tick();
        bus0.we = 1'b0;
        #1;
        check("wr9_npend", 64'(bus0.npend), 64'd0);
        check("wr9_rpend_after", 64'(bus1.rpend), 64'b00);

        // same-edge issue and write
        do_issue(5'd3);
        check("iss3_npend", 64'(bus0.npend), 64'd1);
        bus0.iss      = 1'b1;
        bus0.iss_addr = 5'd3;
        do_write(5'd3, 32'hFFFFFFFF, 4'h0);
        bus0.iss = 1'b0;
        set_rd(5'd3, 5'd4);
        check("same_addr_npend", 64'(bus0.npend), 64'd1);
        check("same_addr_rpend", 64'(bus0.rpend), 64'b01);
        check("wbe0_no_data", 64'(bus0.rdata[31:0]), 64'd0);
        bus0.iss      = 1'b1;
        bus0.iss_addr = 5'd4;
        do_write(5'd3, 32'h0, 4'h0);
        bus0.iss = 1'b0;
        #1;
        check("diff_addr_npend", 64'(bus0.npend), 64'd1);
        check("diff_addr_rpend", 64'(bus0.rpend), 64'b10);
        do_write(5'd4, 32'h0, 4'h0);
        #1;
        check("clr4_npend", 64'(bus0.npend), 64'd0);

        // issue to reg 0, then fill and saturate
        do_issue(5'd0);
        set_rd(5'd0, 5'd0);
        check("iss0_npend", 64'(bus0.npend), 64'd0);
        check("iss0_rpend", 64'(bus0.rpend), 64'b00);
        for (int a = 1; a < 32; a++) do_issue(AW'(a));
        check("fill_npend", 64'(bus0.npend), 64'd31);
        do_issue(5'd1);
        check("reissue_npend", 64'(bus0.npend), 64'd31);
        do_write(5'd10, 32'h00000055, 4'hF);
        set_rd(5'd10, 5'd1);
        check("pre_rst_rdata", 64'(bus1.rdata[31:0]), 64'h55);
        check("pre_rst_npend", 64'(bus0.npend), 64'd30);
        check("pre_rst_rpend", 64'(bus0.rpend), 64'b10);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_rdata", 64'(bus0.rdata), 64'd0);
        check("arst_rdata_nob", 64'(bus1.rdata), 64'd0);
        check("arst_npend", 64'(bus0.npend), 64'd0);
        check("arst_rpend", 64'(bus0.rpend), 64'd0);
        check("arst_stall", 64'(bus0.stall), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rdata", 64'(bus0.rdata), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpr_sb.md
Name: gpr_sb

Overview:
- Next-generation general-purpose register file for the pipelined CPU.
- Generalises the single-cycle GPR in width, depth and read-port count.
- Adds byte-enable writes and a write-to-read bypass.
- Adds a per-register pending scoreboard, so decode can detect RAW hazards against in-flight producers and stall.

Parameters:
DW, 32, data width in bits; must be a multiple of 8.
AW, 5, address width; depth is 2**AW registers.
NRD, 2, number of independent read ports (1..4).
BYPASS, 1, 1 = a read of the register being written this cycle returns the merged new value; 0 = it returns the old value.
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issues; 0 = register 0 is ordinary.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
raddr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
rdata  output  NRD*DW  read data, combinational; port k occupies [k*DW +: DW].
rpend  output  NRD  1 = the register addressed by port k is pending (after write-clear, see below).
stall  output  1  OR of rpend.
we  input  1  write enable.
waddr  input  AW  write address.
wdata  input  DW  write data.
wbe  input  DW/8  byte enables; bit i covers wdata[8i+7:8i].
iss  input  1  issue: marks iss_addr as pending (a producer has entered the pipeline).
iss_addr  input  AW  destination register of the issued instruction.
npend  output  AW+1  count of pending registers.

Behaviour:
- Reset (asynchronous, immediate on rst high): all registers = 0; all pending bits = 0; npend = 0; rdata = 0 for every port; rpend = 0; stall = 0.
- Storage: 2**AW x DW flops, no RAM inference requirement.
- Write: at posedge clk with we=1 and wbe!=0, for each i with wbe[i]=1, reg[waddr] byte i <= wdata byte i. Other bytes are unchanged.
  - we=1 with wbe=0 writes no data but still clears pending.
- Write to register 0 with ZERO_REG=1: no storage change; pending clear is irrelevant.
- Read (combinational, no latency):
  - rdata[k] = 0 if ZERO_REG and raddr[k]==0.
  - Otherwise, if BYPASS and we and raddr[k]==waddr: the stored value with enabled bytes replaced by wdata.
  - Otherwise: reg[raddr[k]].
- Scoreboard, one pending bit per register, updated at posedge clk:
  - we=1 clears pend[waddr], regardless of wbe.
  - iss=1 sets pend[iss_addr]; ignored for address 0 when ZERO_REG=1.
  - Same address, iss and we together: set wins, so pend = 1 (the new producer supersedes the retiring one).
  - Different addresses: both updates take effect.
  - Issue to an already-pending register: stays 1, no double count.
- rpend[k] = pend[raddr[k]], masked to 0 when:
  - ZERO_REG=1 and raddr[k]==0; or
  - BYPASS=1, we=1 and raddr[k]==waddr (value is forwarded this cycle).
  - With BYPASS=0, a register written this cycle still shows rpend=1 until the next edge.
- npend: registered population count of pend, updated on the same edge as pend. Range 0..2**AW.
- Multiple read ports may address the same register, with no interaction between them.
- Reset mid-operation: pending state is lost and all registers are zeroed. The pipeline is flushed by the same reset.
- No X propagation: undriven wbe bits or unused ports must not corrupt other registers.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rdata = 0, rpend = 0, npend = 0; assert rst mid-cycle after writes -> outputs zero immediately, without waiting for a clock edge.
- Write reg 5 = 0xDEADBEEF (wbe=0xF), then write reg 5 = 0x000000AA with wbe=0x1 -> read reg 5 = 0xDEADBEAA; write reg 0 = 0x12345678 -> read reg 0 = 0.
- BYPASS=1: same cycle we=1, waddr=7, wdata=0x11223344, wbe=0x3, old reg7=0xAABBCCDD, raddr[0]=7 -> rdata[0] = 0xAABB3344 before the edge. BYPASS=0 with the same stimulus -> 0xAABBCCDD.
- Issue reg 9 -> next cycle npend=1, raddr[1]=9 gives rpend[1]=1, stall=1. Write reg 9 -> rpend[1]=0 in the write cycle (BYPASS=1), and npend=0 after the edge.
- Same edge: iss_addr=3 and waddr=3 with reg 3 pending -> pend[3] stays 1, npend unchanged; iss_addr=4 with waddr=3 -> pend[3]=0, pend[4]=1.
- Issue to reg 0 (ZERO_REG=1) -> npend stays 0; issue all of regs 1..31 -> npend=31; repeat issue of reg 1 -> npend=31.
